mem_ctrl: RTL and testbench

- Byte-serial RAM responder and arbiter between the instruction-fetch port (IF) and the data-memory port (MEM) on the single 8-bit RAM bus.
- IF streams byte addresses and takes one byte back per cycle. MEM issues whole 1/2/4-byte transactions, which the block serialises into byte cycles.
- MEM has priority. While MEM owns the bus, if_stall_o is high, and IF abandons and restarts its fetch.

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial RAM responder / IF-MEM arbiter.
package mem_ctrl_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        ENABLE    = 1'b1;

    // MEM transaction length codes (2'b11 behaves as a word)
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_TAIL = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Index of the last byte lane touched by a transaction of this length
    function automatic logic [1:0] last_lane(input logic [1:0] len);
        case (len)
            LEN_B:   return 2'd0;
            LEN_H:   return 2'd1;
            LEN_W:   return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM responder: IF streams byte fetches, MEM has priority and
// issues 1/2/4-byte transactions that are serialised into byte cycles.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [7:0]        if_data_o,
    output logic              if_stall_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic              mem_signed_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_data_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        len_q, len_d;
    logic              sgn_q, sgn_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdbuf_q, rdbuf_d;
    logic [31:0]       data_q, data_d;
    logic              done_q, done_d;
    logic              wr_q, wr_d;
    logic [7:0]        dout_q, dout_d;
    logic [31:0]       rd_full;

    // Sign- or zero-extend the assembled load bytes to 32 bits
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  len,
                                                input logic        sgn);
        case (len)
            LEN_B:   return {{24{sgn & raw[7]}}, raw[7:0]};
            LEN_H:   return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Bus mux: IF owns the address bus only while idle; cnt_q is the lane offset
    always_comb begin
        if (state_q == ST_IDLE) begin
            ram_addr_o = if_addr_i;
            if_stall_o = mem_req_i;
        end else begin
            ram_addr_o = base_q + ADDR_W'(cnt_q);
            if_stall_o = 1'b1;
        end
    end

    assign if_data_o  = ram_din_i;
    assign mem_data_o = data_q;
    assign mem_done_o = done_q;
    assign ram_wr_o   = wr_q;
    assign ram_dout_o = dout_q;

    // Next-state, lane capture and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        len_d   = len_q;
        sgn_d   = sgn_q;
        wdata_d = wdata_q;
        rdbuf_d = rdbuf_q;
        data_d  = data_q;
        done_d  = 1'b0;
        wr_d    = 1'b0;
        dout_d  = dout_q;
        rd_full = rdbuf_q;
        rd_full[{cnt_q, 3'b000} +: 8] = ram_din_i;

        case (state_q)
            ST_IDLE: begin
                if (mem_req_i == ENABLE) begin
                    base_d  = mem_addr_i;
                    len_d   = mem_len_i;
                    sgn_d   = mem_signed_i;
                    wdata_d = mem_wdata_i;
                    cnt_d   = '0;
                    rdbuf_d = '0;
                    if (mem_we_i) begin
                        // First write byte is registered so it is on the bus in T1
                        state_d = ST_WR;
                        wr_d    = 1'b1;
                        dout_d  = mem_wdata_i[7:0];
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // RAM returns a byte one cycle after its address: lane cnt-1 arrives now
                if (cnt_q != 2'd0)
                    rdbuf_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram_din_i;
                if (cnt_q == last_lane(len_q))
                    state_d = ST_RD_TAIL;
                else
                    cnt_d = cnt_q + 2'd1;
            end
            ST_RD_TAIL: begin
                data_d  = extend_load(rd_full, len_q, sgn_q);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_WR: begin
                if (cnt_q == last_lane(len_q)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d  = cnt_q + 2'd1;
                    wr_d   = 1'b1;
                    dout_d = wdata_q[{cnt_q + 2'd1, 3'b000} +: 8];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            sgn_q   <= 1'b0;
            wdata_q <= '0;
            rdbuf_q <= '0;
            data_q  <= ZERO_WORD;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            sgn_q   <= sgn_d;
            wdata_q <= wdata_d;
            rdbuf_q <= rdbuf_d;
            data_q  <= data_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed protocol checks plus random
// MEM transactions against a byte-array reference model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_addr_i;
    logic [7:0]  if_data_o;
    logic        if_stall_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic        mem_signed_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_data_o;
    logic        mem_done_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    // Environment RAM (4 KB, address bits [11:0]) with a preload port
    logic [7:0]  ram [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    // Reference model memory and bookkeeping
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] last_data;
    int          n_cmp = 0;
    int          n_fail = 0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_addr_i    (if_addr_i),
        .if_data_o    (if_data_o),
        .if_stall_o   (if_stall_o),
        .mem_req_i    (mem_req_i),
        .mem_we_i     (mem_we_i),
        .mem_len_i    (mem_len_i),
        .mem_signed_i (mem_signed_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_data_o   (mem_data_o),
        .mem_done_o   (mem_done_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wr_o     (ram_wr_o),
        .ram_dout_o   (ram_dout_o),
        .ram_din_i    (ram_din_i)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears one cycle after the address
    always @(posedge clk) begin
        ram_din_i <= ram[ram_addr_o[11:0]];
        if (ram_wr_o) ram[ram_addr_o[11:0]] = ram_dout_o;
        if (pre_we)   ram[pre_addr] = pre_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        tick();
        pre_we = 1'b0;
    endtask

    function automatic int unsigned nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    // Expected load value from the reference memory using plain arithmetic
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] len,
                                             input logic sgn);
        logic [31:0] v = 0;
        logic [31:0] ai;
        int unsigned n = nbytes(len);
        for (int unsigned i = 0; i < n; i++) begin
            ai = a + i;
            v = v + (32'(ref_mem[ai[11:0]]) << (8 * i));
        end
        if (sgn && n == 1 && v >= 32'd128)   v = v - 32'd256;
        if (sgn && n == 2 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    // One MEM transaction starting in the current cycle (T0), IF keeps fetching
    task automatic do_mem(input logic we, input logic [1:0] len, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd);
        int unsigned n   = nbytes(len);
        int unsigned lat = we ? n + 1 : n + 2;
        logic [31:0] exp_data;
        logic [31:0] ai;
        exp_data = we ? last_data : ref_load(a, len, sgn);
        mem_req_i    = 1'b1;
        mem_we_i     = we;
        mem_len_i    = len;
        mem_signed_i = sgn;
        mem_addr_i   = a;
        mem_wdata_i  = wd;
        if_addr_i    = $urandom;
        #1;
        chk("t0_stall", 32'(if_stall_o), 32'd1);
        chk("t0_ifaddr", ram_addr_o, if_addr_i);
        for (int unsigned k = 1; k <= lat; k++) begin
            tick();
            if_addr_i = $urandom;
            #1;
            chk("stall", 32'(if_stall_o), 32'd1);
            chk("done", 32'(mem_done_o), 32'(k == lat));
            if (k <= n) begin
                chk("addr", ram_addr_o, a + (k - 1));
                chk("wr", 32'(ram_wr_o), 32'(we));
                if (we) chk("dout", 32'(ram_dout_o), (wd >> (8 * (k - 1))) & 32'hFF);
            end else if (!we && k == n + 1) begin
                chk("tail_addr", ram_addr_o, a + (n - 1));
                chk("tail_wr", 32'(ram_wr_o), 32'd0);
            end else begin
                chk("wr_off", 32'(ram_wr_o), 32'd0);
            end
            if (k == lat) begin
                chk(we ? "st_data_hold" : "ld_data", mem_data_o, exp_data);
                mem_req_i = 1'b0;
            end
        end
        if (we) begin
            for (int unsigned i = 0; i < n; i++) begin
                ai = a + i;
                ref_mem[ai[11:0]] = 8'((wd >> (8 * i)) & 32'hFF);
            end
        end
        last_data = exp_data;
        tick();
        if_addr_i = $urandom;
        #1;
        chk("idle_stall", 32'(if_stall_o), 32'd0);
        chk("idle_ifaddr", ram_addr_o, if_addr_i);
        chk("idle_done", 32'(mem_done_o), 32'd0);
    endtask

    initial begin
        int          pulses;
        int          bad;
        logic [31:0] ra;
        rst          = 1'b1;
        if_addr_i    = '0;
        mem_req_i    = 1'b0;
        mem_we_i     = 1'b0;
        mem_len_i    = 2'b00;
        mem_signed_i = 1'b0;
        mem_addr_i   = '0;
        mem_wdata_i  = '0;
        last_data    = '0;

        // Reset state
        tick();
        tick();
        rst       = 1'b0;
        if_addr_i = 32'h0000_0ABC;
        #1;
        chk("rst_done", 32'(mem_done_o), 32'd0);
        chk("rst_wr", 32'(ram_wr_o), 32'd0);
        chk("rst_dout", 32'(ram_dout_o), 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_stall", 32'(if_stall_o), 32'd0);
        chk("rst_ifaddr", ram_addr_o, 32'h0000_0ABC);

        // Fill the whole RAM with random bytes (mirrored in ref_mem)
        for (int unsigned i = 0; i < 4096; i++) poke(12'(i), 8'($urandom));

        // IF-only streaming: each byte shows up one cycle after its address
        poke(12'h000, 8'h13);
        poke(12'h001, 8'h00);
        poke(12'h002, 8'h00);
        poke(12'h003, 8'h93);
        for (int unsigned i = 0; i <= 4; i++) begin
            tick();
            if (i < 4) if_addr_i = 32'(i);
            #1;
            chk("if_stall", 32'(if_stall_o), 32'd0);
            if (i > 0) chk("if_data", 32'(if_data_o), 32'(ref_mem[12'(i - 1)]));
        end

        // Directed loads and stores
        poke(12'h100, 8'h78);
        poke(12'h101, 8'h56);
        poke(12'h102, 8'h34);
        poke(12'h103, 8'h12);
        poke(12'h200, 8'h80);
        tick();
        do_mem(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        chk("lw_value", mem_data_o, 32'h1234_5678);
        tick();
        do_mem(1'b0, 2'b00, 1'b1, 32'h0000_0200, 32'h0);
        chk("lb_value", mem_data_o, 32'hFFFF_FF80);
        tick();
        do_mem(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0);
        chk("lbu_value", mem_data_o, 32'h0000_0080);
        tick();
        do_mem(1'b1, 2'b01, 1'b0, 32'h0000_0301, 32'h1234_BEEF);
        tick();
        do_mem(1'b0, 2'b01, 1'b0, 32'h0000_0301, 32'h0);
        chk("lhu_value", mem_data_o, 32'h0000_BEEF);
        tick();
        do_mem(1'b0, 2'b01, 1'b1, 32'h0000_0301, 32'h0);
        chk("lh_value", mem_data_o, 32'hFFFF_BEEF);
        // Word across the 32-bit address wrap, length code 11 treated as word
        tick();
        do_mem(1'b1, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D);
        tick();
        do_mem(1'b0, 2'b11, 1'b1, 32'hFFFF_FFFE, 32'h0);
        chk("wrap_value", mem_data_o, 32'hCAFE_F00D);
        // Back-to-back transactions with only the mandatory idle cycle between
        do_mem(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);

        // Reset mid-store: rst is high across the edge that starts T2
        poke(12'h400, 8'h11);
        poke(12'h401, 8'h22);
        poke(12'h402, 8'h33);
        poke(12'h403, 8'h44);
        tick();
        mem_req_i    = 1'b1;
        mem_we_i     = 1'b1;
        mem_len_i    = 2'b10;
        mem_signed_i = 1'b0;
        mem_addr_i   = 32'h0000_0400;
        mem_wdata_i  = 32'hA1B2_C3D4;
        #1;
        chk("rs_t0_stall", 32'(if_stall_o), 32'd1);
        tick();
        #1;
        chk("rs_t1_wr", 32'(ram_wr_o), 32'd1);
        chk("rs_t1_dout", 32'(ram_dout_o), 32'hD4);
        rst       = 1'b1;
        mem_req_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_wr", 32'(ram_wr_o), 32'd0);
        chk("rs_stall", 32'(if_stall_o), 32'd0);
        chk("rs_data", mem_data_o, 32'd0);
        chk("rs_dout", 32'(ram_dout_o), 32'd0);
        pulses = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mem_done_o !== 1'b0) pulses++;
            tick();
        end
        chk("rs_no_done", 32'(pulses), 32'd0);
        ref_mem[12'h400] = 8'hD4;
        last_data = '0;
        for (int unsigned i = 0; i < 4; i++)
            chk("rs_ram", 32'(ram[12'h400 + 12'(i)]), 32'(ref_mem[12'h400 + 12'(i)]));

        // Random transactions, half of them clustered so loads hit stored data
        for (int unsigned t = 0; t < 40; t++) begin
            ra = ($urandom_range(0, 1) == 0) ? $urandom : 32'h500 + $urandom_range(0, 15);
            tick();
            do_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ra, $urandom);
        end

        // Whole RAM image against the reference model
        bad = 0;
        for (int unsigned i = 0; i < 4096; i++)
            if (ram[12'(i)] !== ref_mem[12'(i)]) bad++;
        chk("ram_image", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
